jtag_tap_master: RTL and testbench
==================================

# jtag_tap_master

Host-side JTAG TAP master that drives TCK/TMS/TDI into a device TAP and captures TDO, for the Nios II debug infrastructure. It is the initiator counterpart of the debug module's JTAG target logic, which uses a 2-bit virtual IR and a 38-bit data register. Use it in self-test harnesses and on-board debug bridges. A command interface in the `clk` domain requests TAP reset, IR scans, DR scans and idle clocking. The block generates a divided TCK, walks the IEEE 1149.1 TAP state machine, and returns the captured shift data.

## Interface
- `CLK_DIV`, default 4: TCK half-period in `clk` cycles. Must be ≥1.
- `MAX_LEN`, default 38: maximum scan length in bits. Also the data bus width.
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `cmd_valid`, input, 1: command request.
- `cmd_ready`, output, 1: master idle; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_type`, input, 2: 0 = TAP reset, 1 = IR scan, 2 = DR scan, 3 = idle clocks.
- `cmd_len`, input, 6: scan length in bits, or idle TCK count.
- `cmd_data`, input, MAX_LEN: TDI bits, LSB shifted first.
- `resp_valid`, output, 1: one-cycle pulse when a command completes.
- `resp_data`, output, MAX_LEN: captured TDO bits, LSB first. Bits at index ≥ len are 0.
- `tap_in_rti`, output, 1: master knows the TAP is in Run-Test/Idle.
- `tck`, output, 1: JTAG clock.
- `tms`, output, 1: JTAG mode select.
- `tdi`, output, 1: JTAG data to the target.
- `tdo`, input, 1: JTAG data from the target. Already synchronous to `clk`.

## Operation
- Reset values:
  - `tck` = 0, `tms` = 1, `tdi` = 0
  - `cmd_ready` = 1, `resp_valid` = 0, `resp_data` = 0, `tap_in_rti` = 0
- Command capture: type, length and data are latched on acceptance. `cmd_ready` drops the next cycle.
- Length clamping: a `cmd_len` greater than `MAX_LEN` is clamped to `MAX_LEN` for scans. Idle commands are not clamped and allow up to 63 clocks.
- States: IDLE, RESET_SEQ, PRE (walk to Shift), SHIFT, POST (walk to RTI), CLOCKS, DONE.
- TAP reset (type 0): TMS sequence 1,1,1,1,1,0, one bit per TCK. Ends in RTI and sets `tap_in_rti`=1.
- Auto reset: an IR, DR or idle command accepted while `tap_in_rti`=0 first runs the 6-TCK reset sequence, then executes the command.
- DR scan (type 2): TMS sequence from RTI, one bit per TCK:
  - PRE: 1, 0, 0 (Select-DR, Capture-DR, Shift-DR).
  - SHIFT: `len` bits. TMS=0 on every bit except 1 on the last (Exit1-DR). TDI = `cmd_data[i]`.
  - POST: 1, 0 (Update-DR, RTI).
- IR scan (type 1): identical to DR scan except PRE is 1, 1, 0, 0.
- Idle (type 3): `len` TCK periods with TMS=0 and TDI=0.
- Zero length: a scan or idle command with `len`=0 produces no TCK activity. It goes straight to DONE with `resp_data`=0.
- Capture: during SHIFT, bit i of `resp_data` = `tdo` sampled on the rising TCK of the i-th shift bit. Non-shift TCKs capture nothing.
- DONE:
  - `resp_valid` pulses for 1 cycle and `cmd_ready` returns to 1 in the same cycle.
  - `resp_data` holds its value until the next scan completes.
  - Type 0 and type 3 commands load `resp_data` = 0.
- `tdi` is 0 whenever the master is not in SHIFT.
- Reset mid-command: asynchronously returns every output to its reset value. Captured data is discarded and no `resp_valid` is produced.

## Timing
- TCK period = 2·CLK_DIV `clk` cycles: a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
- Output update: `tms` and `tdi` update on the `clk` edge that drives `tck` 1→0, so they are stable for the whole low phase. The first bit of a command is driven together with the first `tck` low phase. This phase starts 1 cycle after acceptance; `tck` is already low then.
- TDO sampling: `tdo` is registered on the `clk` edge that drives `tck` 0→1.
- Last TCK: after the final high phase, `tck` returns to 0. DONE/`resp_valid` occurs 1 cycle after that.
- TCK period counts:
  - DR scan: 5 + L periods.
  - IR scan: 6 + L periods.
  - TAP reset: 6 periods.
  - Idle: L periods.
  - Auto reset adds 6 periods.
- Latency, DR scan with L=38, CLK_DIV=4, TAP already in RTI: 1 + 43·8 + 1 = 346 cycles from acceptance to `resp_valid`.
- Idle output levels: `tck` is held at 0 and `tms` at its last value (0 in RTI).

## Test plan
- TAP reset at CLK_DIV=1 from power-on:
  - TMS per rising TCK = 1,1,1,1,1,0; exactly 6 TCK pulses.
  - `resp_valid` at cycle 1+12+1=14 after acceptance; `tap_in_rti`=1.
- DR scan, L=38, data=38'h2A_5A5A_5A5A, with a TAP model looping TDI→TDO through a 1-bit delay:
  - TMS sequence 1,0,0, then 0×37, 1, then 1,0.
  - `resp_data` = data shifted left 1, bit 0 = model's initial 0.
  - Takes 346 cycles at CLK_DIV=4.
- IR scan with L=2, data=2'b10 issued right after reset:
  - Auto-reset (6 TCK) precedes the scan; 1,1,0,0 PRE.
  - TDI bits 0,1 appear during Shift-IR; TMS=1 on the second shift bit.
- Boundaries:
  - DR scan with `cmd_len`=0: no TCK edge, and `resp_valid` 2 cycles after acceptance with `resp_data`=0.
  - `cmd_len`=50: exactly 38 shift bits are produced.
- Idle with L=5: exactly 5 TCK pulses, TMS=0 and TDI=0 throughout, `resp_data`=0.
- `reset` asserted mid-SHIFT:
  - Immediately `tck`=0, `tms`=1, `cmd_ready`=1, `tap_in_rti`=0, and no `resp_valid`.
  - The next DR command starts with the 6-TCK reset sequence.

Source files
------------

// File: rtl/jtag_tap_master.sv
// Host-side JTAG TAP master: divides clk into TCK, walks the 1149.1 TAP state machine for
// reset, IR/DR scans and idle clocking, and returns the TDO bits captured while shifting.
module jtag_tap_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 38
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               resp_valid,
    output logic [MAX_LEN-1:0] resp_data,
    output logic               tap_in_rti,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] TypeReset = 2'd0;
    localparam logic [1:0] TypeIr    = 2'd1;
    localparam logic [1:0] TypeDr    = 2'd2;
    localparam logic [1:0] TypeIdle  = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StStart, StResetSeq, StPre, StShift, StPost, StClocks, StDone
    } state_e;

    state_e             state_q, state_d, nxt_state;
    logic [5:0]         cnt_q, cnt_d, nxt_cnt;
    logic [DivW-1:0]    div_q, div_d;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic               rti_q, rti_d, rvalid_q, rvalid_d;
    logic [1:0]         type_q, type_d;
    logic [5:0]         len_q, len_d, pre_last;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, resp_q, resp_d;
    logic               step;

    assign cmd_ready  = (state_q == StIdle);
    assign resp_valid = rvalid_q;
    assign resp_data  = resp_q;
    assign tap_in_rti = rti_q;
    assign tck        = tck_q;
    assign tms        = tms_q;
    assign tdi        = tdi_q;
    assign pre_last   = (type_q == TypeIr) ? 6'd3 : 6'd2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        tck_d    = tck_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
        rti_d    = rti_q;
        rvalid_d = 1'b0;
        type_d   = type_q;
        len_d    = len_q;
        data_d   = data_q;
        cap_d    = cap_q;
        resp_d   = resp_q;
        step     = 1'b0;

        // Which TAP bit follows the one currently on the wires.
        nxt_state = StDone;
        nxt_cnt   = '0;
        case (state_q)
            StStart: begin
                if (len_q == '0 && type_q != TypeReset) nxt_state = StDone;
                else if (type_q == TypeReset || !rti_q) nxt_state = StResetSeq;
                else if (type_q == TypeIdle)            nxt_state = StClocks;
                else                                    nxt_state = StPre;
            end
            StResetSeq: begin
                if (cnt_q != 6'd5) begin
                    nxt_state = StResetSeq;
                    nxt_cnt   = cnt_q + 6'd1;
                end else if (type_q == TypeIdle) begin
                    nxt_state = StClocks;
                end else if (type_q != TypeReset) begin
                    nxt_state = StPre;
                end
            end
            StPre: begin
                if (cnt_q != pre_last) begin
                    nxt_state = StPre;
                    nxt_cnt   = cnt_q + 6'd1;
                end else begin
                    nxt_state = StShift;
                end
            end
            StShift: begin
                nxt_state = StPost;
                if (cnt_q != len_q - 6'd1) begin
                    nxt_state = StShift;
                    nxt_cnt   = cnt_q + 6'd1;
                end
            end
            StPost: begin
                if (cnt_q == '0) begin
                    nxt_state = StPost;
                    nxt_cnt   = 6'd1;
                end
            end
            StClocks: begin
                if (cnt_q != len_q - 6'd1) begin
                    nxt_state = StClocks;
                    nxt_cnt   = cnt_q + 6'd1;
                end
            end
            default: ;
        endcase

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    type_d  = cmd_type;
                    data_d  = cmd_data;
                    cap_d   = '0;
                    len_d   = cmd_len;
                    if (cmd_type != TypeIdle && 32'(cmd_len) > MAX_LEN) len_d = 6'(MAX_LEN);
                    state_d = StStart;
                end
            end
            StStart: step = 1'b1;
            StResetSeq, StPre, StShift, StPost, StClocks: begin
                div_d = div_q + DivW'(1);
                if (div_q == DivW'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!tck_q) begin
                        tck_d = 1'b1;
                        if (state_q == StShift) cap_d[cnt_q] = tdo;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d  = StIdle;
                rvalid_d = 1'b1;
                resp_d   = (type_q == TypeIr || type_q == TypeDr) ? cap_q : '0;
            end
            default: state_d = StIdle;
        endcase

        // Falling TCK (or launch): drive the next bit for the whole low phase.
        if (step) begin
            state_d = nxt_state;
            cnt_d   = nxt_cnt;
            div_d   = '0;
            tck_d   = 1'b0;
            tdi_d   = (nxt_state == StShift) ? data_q[nxt_cnt] : 1'b0;
            case (nxt_state)
                StResetSeq: tms_d = (nxt_cnt != 6'd5);
                StPre:      tms_d = (nxt_cnt == '0) || (type_q == TypeIr && nxt_cnt == 6'd1);
                StShift:    tms_d = (nxt_cnt == len_q - 6'd1);
                StPost:     tms_d = (nxt_cnt == '0);
                StClocks:   tms_d = 1'b0;
                default:    tms_d = tms_q;
            endcase
            if (state_q == StStart) begin
                if (nxt_state != StDone) rti_d = 1'b0;
            end else if (nxt_state == StDone) begin
                rti_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            div_q    <= '0;
            tck_q    <= 1'b0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            rti_q    <= 1'b0;
            rvalid_q <= 1'b0;
            type_q   <= TypeReset;
            len_q    <= '0;
            data_q   <= '0;
            cap_q    <= '0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            tck_q    <= tck_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            rti_q    <= rti_d;
            rvalid_q <= rvalid_d;
            type_q   <= type_d;
            len_q    <= len_d;
            data_q   <= data_d;
            cap_q    <= cap_d;
            resp_q   <= resp_d;
        end
    end
endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master: a CLK_DIV=4 instance with a 1-bit TDI->TDO loopback
// TAP model, plus a CLK_DIV=1 instance for the fast reset sequence.
module tb_jtag_tap_master;
    localparam logic [37:0] DR_DATA = 38'h2A_5A5A_5A5A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_valid_f = 1'b0;
    logic [1:0]  cmd_type = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [37:0] cmd_data = '0;
    logic        cmd_ready, resp_valid, tap_in_rti, tck, tms, tdi;
    logic [37:0] resp_data;
    logic        cmd_ready_f, resp_valid_f, tap_in_rti_f, tck_f, tms_f, tdi_f;
    logic [37:0] resp_data_f;

    logic        model_q = 1'b0;
    logic        tck_prev = 1'b0, tck_prev_f = 1'b0;
    logic [9:0]  n_rise = '0, n_rise_f = '0;
    logic        tms_log [1024];
    logic        tdi_log [1024];
    logic        tms_log_f [1024];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtag_tap_master #(.CLK_DIV(4), .MAX_LEN(38)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .tap_in_rti(tap_in_rti),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(model_q)
    );

    jtag_tap_master #(.CLK_DIV(1), .MAX_LEN(38)) dut_fast (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_f), .cmd_ready(cmd_ready_f),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .resp_valid(resp_valid_f), .resp_data(resp_data_f), .tap_in_rti(tap_in_rti_f),
        .tck(tck_f), .tms(tms_f), .tdi(tdi_f), .tdo(1'b0)
    );

    // Log TMS/TDI at each rising TCK; the TAP model echoes TDI one TCK later.
    always @(negedge clk) begin
        tck_prev   <= tck;
        tck_prev_f <= tck_f;
        if (tck && !tck_prev) begin
            tms_log[n_rise] <= tms;
            tdi_log[n_rise] <= tdi;
            n_rise          <= n_rise + 10'd1;
            model_q         <= tdi;
        end
        if (tck_f && !tck_prev_f) begin
            tms_log_f[n_rise_f] <= tms_f;
            n_rise_f            <= n_rise_f + 10'd1;
        end
    end

    task automatic run_cmd(input logic [1:0] t, input logic [5:0] l, input logic [37:0] d,
                           output int cyc, output int base);
        @(negedge clk);
        base      = int'(n_rise);
        cmd_type  = t;
        cmd_len   = l;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic get_logs(input int base, output int n, output logic [63:0] tv,
                            output logic [63:0] dv);
        n  = int'(n_rise) - base;
        tv = '0;
        dv = '0;
        for (int i = 0; i < n && i < 64; i++) begin
            tv[i] = tms_log[10'(base + i)];
            dv[i] = tdi_log[10'(base + i)];
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({tck, tms, tdi} !== 3'b010) begin
            errors++;
            $display("FAIL reset_pins: tck/tms/tdi got %b expected 010", {tck, tms, tdi});
        end
        checks++;
        if ({cmd_ready, resp_valid, tap_in_rti} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: ready/rvalid/rti got %b expected 100",
                     {cmd_ready, resp_valid, tap_in_rti});
        end
        checks++;
        if (resp_data !== 38'd0) begin
            errors++;
            $display("FAIL reset_resp: got %h expected 0", resp_data);
        end
    endtask

    task automatic test_reset_fast;
        int cyc;
        int base;
        logic [5:0] tv;
        @(negedge clk);
        base        = int'(n_rise_f);
        cmd_type    = 2'd0;
        cmd_len     = 6'd0;
        cmd_valid_f = 1'b1;
        @(posedge clk);
        #1 cmd_valid_f = 1'b0;
        checks++;
        if (cmd_ready_f !== 1'b0) begin
            errors++;
            $display("FAIL fast_ready_drop: got %b expected 0", cmd_ready_f);
        end
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid_f) begin
                cyc = i;
                break;
            end
        end
        tv = '0;
        for (int i = 0; i < 6; i++) tv[i] = tms_log_f[10'(base + i)];
        checks++;
        if (cyc !== 14) begin
            errors++;
            $display("FAIL fast_reset_latency: got %0d expected 14", cyc);
        end
        checks++;
        if (int'(n_rise_f) - base !== 6) begin
            errors++;
            $display("FAIL fast_reset_pulses: got %0d expected 6", int'(n_rise_f) - base);
        end
        checks++;
        if (tv !== 6'b011111) begin
            errors++;
            $display("FAIL fast_reset_tms: got %b expected 011111 (bit0 first)", tv);
        end
        checks++;
        if (tap_in_rti_f !== 1'b1 || cmd_ready_f !== 1'b1) begin
            errors++;
            $display("FAIL fast_reset_rti: rti/ready got %b%b expected 11",
                     tap_in_rti_f, cmd_ready_f);
        end
    endtask

    task automatic test_ir_autoreset;
        int cyc, base, n;
        logic [63:0] tv, dv;
        run_cmd(2'd1, 6'd2, 38'b10, cyc, base);
        get_logs(base, n, tv, dv);
        checks++;
        if (cyc !== 114) begin
            errors++;
            $display("FAIL ir_latency: got %0d expected 114", cyc);
        end
        checks++;
        if (n !== 14) begin
            errors++;
            $display("FAIL ir_pulses: got %0d expected 14", n);
        end
        checks++;
        if (tv !== 64'h18DF) begin
            errors++;
            $display("FAIL ir_tms: got %h expected 18df", tv);
        end
        checks++;
        if (dv !== 64'h0800) begin
            errors++;
            $display("FAIL ir_tdi: got %h expected 0800", dv);
        end
        checks++;
        if (tap_in_rti !== 1'b1 || resp_data !== 38'd0) begin
            errors++;
            $display("FAIL ir_end: rti=%b resp=%h expected rti=1 resp=0", tap_in_rti, resp_data);
        end
    endtask

    task automatic test_dr_scan;
        int cyc, base, n;
        logic [63:0] tv, dv, exp_tdi;
        logic [37:0] d;
        d       = DR_DATA;
        exp_tdi = 64'(d) << 3;
        run_cmd(2'd2, 6'd38, d, cyc, base);
        get_logs(base, n, tv, dv);
        checks++;
        if (cyc !== 346) begin
            errors++;
            $display("FAIL dr_latency: got %0d expected 346", cyc);
        end
        checks++;
        if (n !== 43) begin
            errors++;
            $display("FAIL dr_pulses: got %0d expected 43", n);
        end
        checks++;
        if (tv !== 64'h0000_0300_0000_0001) begin
            errors++;
            $display("FAIL dr_tms: got %h expected 0000030000000001", tv);
        end
        checks++;
        if (dv !== exp_tdi) begin
            errors++;
            $display("FAIL dr_tdi: got %h expected %h", dv, exp_tdi);
        end
        checks++;
        if (resp_data !== 38'h14_B4B4_B4B4) begin
            errors++;
            $display("FAIL dr_resp: got %h expected 14b4b4b4b4", resp_data);
        end
    endtask

    task automatic test_zero_len;
        int cyc, base, n;
        logic [63:0] tv, dv;
        run_cmd(2'd2, 6'd0, 38'h3F_FFFF_FFFF, cyc, base);
        get_logs(base, n, tv, dv);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL zero_latency: got %0d expected 2", cyc);
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL zero_pulses: got %0d expected 0", n);
        end
        checks++;
        if (resp_data !== 38'd0) begin
            errors++;
            $display("FAIL zero_resp: got %h expected 0", resp_data);
        end
    endtask

    task automatic test_clamp;
        int cyc, base, n;
        logic [63:0] tv, dv;
        run_cmd(2'd2, 6'd50, 38'h3F_FFFF_FFFF, cyc, base);
        get_logs(base, n, tv, dv);
        checks++;
        if (n !== 43 || cyc !== 346) begin
            errors++;
            $display("FAIL clamp_len: pulses=%0d cycles=%0d expected 43/346", n, cyc);
        end
        checks++;
        if (dv !== 64'h0000_01FF_FFFF_FFF8) begin
            errors++;
            $display("FAIL clamp_tdi: got %h expected 000001fffffffff8", dv);
        end
        checks++;
        if (resp_data !== 38'h3F_FFFF_FFFE) begin
            errors++;
            $display("FAIL clamp_resp: got %h expected 3ffffffffe", resp_data);
        end
    endtask

    task automatic test_idle;
        int cyc, base, n;
        logic [63:0] tv, dv;
        run_cmd(2'd3, 6'd5, 38'h3F_FFFF_FFFF, cyc, base);
        get_logs(base, n, tv, dv);
        checks++;
        if (cyc !== 42 || n !== 5) begin
            errors++;
            $display("FAIL idle_clocks: cycles=%0d pulses=%0d expected 42/5", cyc, n);
        end
        checks++;
        if (tv !== 64'd0 || dv !== 64'd0) begin
            errors++;
            $display("FAIL idle_levels: tms=%h tdi=%h expected 0/0", tv, dv);
        end
        checks++;
        if (resp_data !== 38'd0 || tap_in_rti !== 1'b1) begin
            errors++;
            $display("FAIL idle_resp: resp=%h rti=%b expected 0/1", resp_data, tap_in_rti);
        end
    endtask

    task automatic test_reset_mid_shift;
        int cyc, base, n, start;
        logic [63:0] tv, dv;
        logic seen, reached;
        @(negedge clk);
        start     = int'(n_rise);
        cmd_type  = 2'd2;
        cmd_len   = 6'd38;
        cmd_data  = DR_DATA;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (int'(n_rise) - start >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midreset_reach_shift: got %0d pulses expected 10",
                     int'(n_rise) - start);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tck, tms, tdi, cmd_ready, tap_in_rti, resp_valid} !== 6'b010100) begin
            errors++;
            $display("FAIL midreset_outputs: tck/tms/tdi/ready/rti/rvalid got %b expected 010100",
                     {tck, tms, tdi, cmd_ready, tap_in_rti, resp_valid});
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_resp: resp_valid got %b expected 0", seen);
        end
        run_cmd(2'd2, 6'd1, 38'd1, cyc, base);
        get_logs(base, n, tv, dv);
        checks++;
        if (cyc !== 98 || n !== 12) begin
            errors++;
            $display("FAIL midreset_autoreset: cycles=%0d pulses=%0d expected 98/12", cyc, n);
        end
        checks++;
        if (tv !== 64'h065F || dv !== 64'h0200) begin
            errors++;
            $display("FAIL midreset_seq: tms=%h tdi=%h expected 065f/0200", tv, dv);
        end
    endtask

    initial begin
        test_reset;
        test_reset_fast;
        test_ir_autoreset;
        test_dr_scan;
        test_zero_len;
        test_clamp;
        test_idle;
        test_reset_mid_shift;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
